// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment encodings,
// digit geometry and the anode rotator's reset pattern.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned VALUE_W    = NUM_DIGITS * NIBBLE_W;

    localparam logic [SEG_W-1:0]      SEG_OFF   = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] ANODE_RST = 8'hFE;

    // Active-low {g,f,e,d,c,b,a} patterns, entry n is hex digit n.
    localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [NIBBLE_W-1:0] hex,
    output logic [SEG_W-1:0]    seg_c
);

    assign seg_c = HEX_SEG[hex];

endmodule

// File: rtl/seg_scan_driver.sv
// Cathode driver for an 8-digit multiplexed display: refresh prescaler,
// post-rotation blanking and frame-synchronous double buffering of the value.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_DIGITS-1:0] anode,
    input  logic [VALUE_W-1:0]    value,
    input  logic [NUM_DIGITS-1:0] dp,
    input  logic [NUM_DIGITS-1:0] digit_en,
    input  logic                  load,
    output logic                  rotate,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp_n,
    output logic                  pending
);

    localparam int unsigned DIV_W   = $clog2(REFRESH_DIV);
    localparam int unsigned BLANK_W = (BLANK_CYCLES == 0) ? 1 : $clog2(BLANK_CYCLES + 1);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
    localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]    div_cnt;
    logic [BLANK_W-1:0]  blank_cnt;
    logic [VALUE_W-1:0]  pend_val;
    logic [VALUE_W-1:0]  shadow_val;
    logic [3:0]          zero_cnt;
    logic [IDX_W-1:0]    idx;
    logic                anode_ok;
    logic                boundary;
    logic [NIBBLE_W-1:0] nib;
    logic [SEG_W-1:0]    hex_seg;
    logic [SEG_W-1:0]    seg_d;
    logic                dp_n_d;

    // Prescaler: rotate is the registered terminal count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            rotate  <= 1'b0;
        end else begin
            rotate  <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end
    end

    // Anode decode: index of the single low bit, plus a one-hot validity check.
    always_comb begin
        zero_cnt = '0;
        idx      = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!anode[i]) begin
                zero_cnt = zero_cnt + 4'd1;
                idx      = IDX_W'(i);
            end
        end
    end

    assign anode_ok = (zero_cnt == 4'd1);
    assign boundary = rotate && anode_ok && (idx == LAST_IDX);

    // Blanking restarts on the edge where the rotator moves to the next digit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blank_cnt <= BLANK_LOAD;
        end else if (rotate) begin
            blank_cnt <= BLANK_LOAD;
        end else if (blank_cnt != '0) begin
            blank_cnt <= blank_cnt - BLANK_W'(1);
        end
    end

    // Double buffer: a load in the boundary cycle bypasses the pending stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_val   <= '0;
            shadow_val <= '0;
            pending    <= 1'b0;
        end else if (boundary) begin
            if (load) begin
                shadow_val <= value;
            end else if (pending) begin
                shadow_val <= pend_val;
            end
            pending <= 1'b0;
        end else if (load) begin
            pend_val <= value;
            pending  <= 1'b1;
        end
    end

    assign nib = shadow_val[{idx, 2'b00} +: NIBBLE_W];

    hex_to_seg7 u_dec (
        .hex   (nib),
        .seg_c (hex_seg)
    );

    always_comb begin
        seg_d  = SEG_OFF;
        dp_n_d = 1'b1;
        if ((blank_cnt == '0) && anode_ok) begin
            seg_d  = digit_en[idx] ? hex_seg : SEG_OFF;
            dp_n_d = ~(dp[idx] & digit_en[idx]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg  <= SEG_OFF;
            dp_n <= 1'b1;
        end else begin
            seg  <= seg_d;
            dp_n <= dp_n_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with a behavioural anode rotator.
module tb_seg_scan_driver;

    localparam int unsigned RDIV  = 4;
    localparam int unsigned BLANK = 1;

    localparam int SIG_SEG  = 0;
    localparam int SIG_DPN  = 1;
    localparam int SIG_PEND = 2;
    localparam int SIG_ROT  = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  anode;
    logic [7:0]  anode_model;
    logic [7:0]  anode_force_val = 8'hFC;
    logic        force_en = 1'b0;
    logic [31:0] value;
    logic [7:0]  dp;
    logic [7:0]  digit_en;
    logic        load;
    logic        rotate;
    logic [6:0]  seg;
    logic        dp_n;
    logic        pending;

    typedef struct {
        int         cyc;
        int         sig;
        logic [6:0] val;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    seg_scan_driver #(
        .REFRESH_DIV  (RDIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk      (clk),
        .rst      (rst_n),
        .anode    (anode),
        .value    (value),
        .dp       (dp),
        .digit_en (digit_en),
        .load     (load),
        .rotate   (rotate),
        .seg      (seg),
        .dp_n     (dp_n),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    // Anode rotator model: shifts the low bit toward the next digit on rotate.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      anode_model <= 8'hFE;
        else if (rotate) anode_model <= {anode_model[6:0], anode_model[7]};
    end

    assign anode = force_en ? anode_force_val : anode_model;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic expect_at(input int c, input int s, input logic [6:0] v, input string nm);
        exp_t e;
        e.cyc  = c;
        e.sig  = s;
        e.val  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_load(input int at, input logic [31:0] v, input logic [7:0] d,
                           input logic [7:0] en);
        wait_cyc(at);
        value    = v;
        dp       = d;
        digit_en = en;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Monitor: compares every queued expectation once its cycle is reached.
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [6:0] act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            case (e.sig)
                SIG_SEG:  act = seg;
                SIG_DPN:  act = {6'b0, dp_n};
                SIG_PEND: act = {6'b0, pending};
                default:  act = {6'b0, rotate};
            endcase
            n_cmp++;
            if (act !== e.val) begin
                n_bad++;
                $display("FAIL %s @cyc %0d: got %h expected %h", e.name, cyc, act, e.val);
            end
        end
    end

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: run did not complete, %0d expectations left", q.size());
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : stim
        logic [6:0] scan_seg [8];
        scan_seg = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};

        value    = '0;
        dp       = '0;
        digit_en = 8'hFF;
        load     = 1'b0;

        expect_at(0, SIG_SEG,  7'h7F, "rst_seg");
        expect_at(0, SIG_DPN,  7'h01, "rst_dpn");
        expect_at(0, SIG_PEND, 7'h00, "rst_pend");
        expect_at(0, SIG_ROT,  7'h00, "rst_rot");
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Reset release: one blank cycle, then digit 0 of value 0.
        expect_at(1, SIG_SEG, 7'h7F, "boot_blank");
        expect_at(2, SIG_SEG, 7'h40, "boot_d0");
        expect_at(2, SIG_DPN, 7'h01, "boot_dpn");
        expect_at(4, SIG_ROT, 7'h01, "rot_first");
        expect_at(5, SIG_ROT, 7'h00, "rot_one_cycle");
        expect_at(5, SIG_SEG, 7'h40, "rot_edge_seg");
        expect_at(6, SIG_SEG, 7'h7F, "slot_blank");
        expect_at(7, SIG_SEG, 7'h40, "boot_d1");
        expect_at(8, SIG_ROT, 7'h01, "rot_period");

        // Full scan of 89ABCDEF after the frame boundary at edge 33.
        expect_at(9,  SIG_PEND, 7'h00, "scan_pend_pre");
        expect_at(10, SIG_PEND, 7'h01, "scan_pend_set");
        expect_at(32, SIG_PEND, 7'h01, "scan_pend_hold");
        expect_at(33, SIG_PEND, 7'h00, "scan_pend_clr");
        for (int d = 0; d < 8; d++) begin
            expect_at(34 + 4*d, SIG_SEG, 7'h7F, $sformatf("scan_blank%0d", d));
            expect_at(35 + 4*d, SIG_SEG, scan_seg[d], $sformatf("scan_seg%0d", d));
            expect_at(35 + 4*d, SIG_DPN, (d == 0) ? 7'h00 : 7'h01, $sformatf("scan_dpn%0d", d));
        end

        // Tear-free update loaded while digit 3 is lit.
        expect_at(78, SIG_PEND, 7'h00, "tear_pend_pre");
        expect_at(79, SIG_PEND, 7'h01, "tear_pend_set");
        expect_at(79, SIG_SEG,  7'h46, "tear_old_d3");
        expect_at(83, SIG_SEG,  7'h03, "tear_old_d4");
        expect_at(95, SIG_SEG,  7'h00, "tear_old_d7");
        expect_at(96, SIG_PEND, 7'h01, "tear_pend_hold");
        expect_at(97, SIG_PEND, 7'h00, "tear_pend_clr");
        expect_at(98, SIG_SEG,  7'h7F, "tear_blank_d0");
        expect_at(99, SIG_SEG,  7'h79, "tear_new_d0");
        expect_at(103, SIG_SEG, 7'h79, "tear_new_d1");

        // Load coinciding with the boundary beats the older pending value.
        expect_at(105, SIG_PEND, 7'h01, "simul_pend_old");
        expect_at(128, SIG_ROT,  7'h01, "simul_rot");
        expect_at(128, SIG_PEND, 7'h01, "simul_pend_pre");
        expect_at(129, SIG_PEND, 7'h00, "simul_pend_clr");
        expect_at(131, SIG_SEG,  7'h24, "simul_d0");
        expect_at(135, SIG_SEG,  7'h24, "simul_d1");

        // Upper digits disabled, all decimal points requested.
        expect_at(143, SIG_SEG, 7'h24, "dis_d3_seg");
        expect_at(143, SIG_DPN, 7'h00, "dis_d3_dpn");
        expect_at(147, SIG_SEG, 7'h7F, "dis_d4_seg");
        expect_at(147, SIG_DPN, 7'h01, "dis_d4_dpn");
        expect_at(159, SIG_SEG, 7'h7F, "dis_d7_seg");
        expect_at(159, SIG_DPN, 7'h01, "dis_d7_dpn");

        // Invalid anode blanks output but leaves the prescaler running.
        expect_at(172, SIG_SEG, 7'h7F, "inv_seg_a");
        expect_at(172, SIG_DPN, 7'h01, "inv_dpn");
        expect_at(172, SIG_ROT, 7'h01, "inv_rot_a");
        expect_at(176, SIG_SEG, 7'h7F, "inv_seg_b");
        expect_at(176, SIG_ROT, 7'h01, "inv_rot_b");
        expect_at(183, SIG_SEG, 7'h24, "inv_recover");
        expect_at(183, SIG_PEND, 7'h00, "inv_pend");

        // Pending load that the mid-slot reset must discard.
        expect_at(186, SIG_PEND, 7'h01, "mid_pend_set");
        expect_at(188, SIG_SEG,  7'h24, "mid_seg_pre");

        do_load(9, 32'h89AB_CDEF, 8'h01, 8'hFF);
        do_load(78, 32'h1111_1111, 8'h01, 8'hFF);
        do_load(104, 32'h3333_3333, 8'h00, 8'hFF);
        do_load(128, 32'h2222_2222, 8'h00, 8'hFF);

        wait_cyc(134);
        digit_en = 8'h0F;
        dp       = 8'hFF;
        wait_cyc(160);
        digit_en = 8'hFF;
        dp       = 8'h00;

        wait_cyc(170);
        force_en = 1'b1;
        wait_cyc(180);
        force_en = 1'b0;

        do_load(185, 32'h4444_4444, 8'h00, 8'hFF);

        // Asynchronous reset asserted between edges in the middle of a slot.
        wait_cyc(189);
        #1;
        expect_at(0, SIG_SEG,  7'h7F, "arst_seg");
        expect_at(0, SIG_DPN,  7'h01, "arst_dpn");
        expect_at(0, SIG_PEND, 7'h00, "arst_pend");
        expect_at(0, SIG_ROT,  7'h00, "arst_rot");
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2;
        expect_at(2,  SIG_SEG,  7'h40, "post_d0");
        expect_at(2,  SIG_DPN,  7'h01, "post_dpn");
        expect_at(4,  SIG_ROT,  7'h01, "post_rot");
        expect_at(10, SIG_PEND, 7'h00, "post_pend");
        expect_at(34, SIG_SEG,  7'h7F, "post_blank_f1");
        expect_at(35, SIG_SEG,  7'h40, "post_d0_f1");
        expect_at(39, SIG_SEG,  7'h40, "post_d1_f1");
        @(negedge clk);
        #2 rst_n = 1'b1;

        wait_cyc(40);
        repeat (4) @(negedge clk);
        if (q.size() != 0) begin
            $display("FAIL leftover: %0d expectations never reached", q.size());
            n_bad += q.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
